// File: rtl/imm_parser_pkg.sv
// rtl/imm_parser_pkg.sv - FSM state type and ASCII classification helpers for imm_parser
package imm_parser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SIGN,
        ZERO,
        HEX,
        DEC,
        DONE,
        ERR
    } imm_parser_state;

    function automatic logic is_delim(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h2C) || (c == 8'h28) || (c == 8'h29) ||
               (c == 8'h0A) || (c == 8'h0D) || (c == 8'h00);
    endfunction

    function automatic logic is_num(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_hex_digit(input logic [7:0] c);
        return is_num(c) || ((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    function automatic logic [3:0] ascii_to_hex(input logic [7:0] c);
        logic [7:0] v;
        if (is_num(c))
            v = c - 8'h30;
        else if (c >= 8'h61)
            v = c - 8'h57;
        else
            v = c - 8'h37;
        return v[3:0];
    endfunction

endpackage

// File: rtl/imm_parser.sv
// rtl/imm_parser.sv - streaming signed decimal / 0x-hex literal parser; IMM_PARSER_RANGE_CHECK_EN enables overflow checks
module imm_parser
    import imm_parser_pkg::*;
#(
    parameter int IMM_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic [7:0]           char_in,
    input  logic                 char_valid_in,
    output logic                 char_ready_out,
    output logic [IMM_WIDTH-1:0] imm_out,
    output logic                 imm_valid_out,
    output logic                 error_out,
    output logic [7:0]           term_char_out
);

    imm_parser_state state, state_nx;

    logic [IMM_WIDTH-1:0] acc, imm_q, dec_next, hex_next, result;
    logic                 neg, seen_minus;
    logic [7:0]           hex_cnt, term_pend, term_q;
    logic                 xfer, delim, num, hexd, minus;
    logic [3:0]           digit;
    logic                 hex_ovf, dec_ovf, neg_ovf;

    assign xfer     = char_valid_in && char_ready_out;
    assign delim    = is_delim(char_in);
    assign num      = is_num(char_in);
    assign hexd     = is_hex_digit(char_in);
    assign minus    = (char_in == 8'h2D);
    assign digit    = ascii_to_hex(char_in);
    assign hex_next = {acc[IMM_WIDTH-5:0], digit};
    assign result   = neg ? (~acc + 1'b1) : acc;

`ifdef IMM_PARSER_RANGE_CHECK_EN
    localparam logic [IMM_WIDTH-1:0] NEG_LIMIT = {1'b1, {(IMM_WIDTH-1){1'b0}}};
    logic [IMM_WIDTH+3:0] dec_wide;
    // Four extra bits hold any carry out of acc*10+9
    assign dec_wide = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + (IMM_WIDTH+4)'(digit);
    assign dec_next = dec_wide[IMM_WIDTH-1:0];
    assign dec_ovf  = |dec_wide[IMM_WIDTH+3:IMM_WIDTH];
    assign hex_ovf  = (hex_cnt >= 8'(IMM_WIDTH/4));
    assign neg_ovf  = neg && (acc > NEG_LIMIT);
`else
    assign dec_next = (acc << 3) + (acc << 1) + IMM_WIDTH'(digit);
    assign dec_ovf  = 1'b0;
    assign hex_ovf  = 1'b0;
    assign neg_ovf  = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start_in) begin
            state_nx = SIGN;
        end else begin
            case (state)
                SIGN: if (xfer) begin
                    if (minus && !seen_minus) state_nx = SIGN;
                    else if (char_in == 8'h30) state_nx = ZERO;
                    else if (num)              state_nx = DEC;
                    else                       state_nx = ERR;
                end
                ZERO: if (xfer) begin
                    if ((char_in == 8'h78) || (char_in == 8'h58)) state_nx = HEX;
                    else if (num)   state_nx = DEC;
                    else if (delim) state_nx = DONE;
                    else            state_nx = ERR;
                end
                HEX: if (xfer) begin
                    if (hexd && !hex_ovf)                           state_nx = HEX;
                    else if (delim && (hex_cnt != 8'd0) && !neg_ovf) state_nx = DONE;
                    else                                            state_nx = ERR;
                end
                DEC: if (xfer) begin
                    if (num && !dec_ovf)      state_nx = DEC;
                    else if (delim && !neg_ovf) state_nx = DONE;
                    else                      state_nx = ERR;
                end
                DONE, ERR: state_nx = IDLE;
                default:   state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc        <= '0;
            neg        <= 1'b0;
            seen_minus <= 1'b0;
            hex_cnt    <= 8'd0;
            term_pend  <= 8'd0;
        end else if (start_in) begin
            acc        <= '0;
            neg        <= 1'b0;
            seen_minus <= 1'b0;
            hex_cnt    <= 8'd0;
        end else if (xfer) begin
            case (state)
                SIGN: begin
                    if (minus && !seen_minus) begin
                        neg        <= 1'b1;
                        seen_minus <= 1'b1;
                    end else if (num) begin
                        acc <= IMM_WIDTH'(digit);
                    end
                end
                ZERO: if (num) acc <= IMM_WIDTH'(digit);
                HEX: if (hexd) begin
                    acc <= hex_next;
                    if (hex_cnt != 8'hFF) hex_cnt <= hex_cnt + 8'd1;
                end
                DEC: if (num) acc <= dec_next;
                default: ;
            endcase
            if ((state_nx == DONE) || (state_nx == ERR)) term_pend <= char_in;
        end
    end

    // Visible registers only follow a pulse that start_in did not suppress
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            imm_q  <= '0;
            term_q <= 8'd0;
        end else begin
            if (imm_valid_out) imm_q <= result;
            if (imm_valid_out || error_out) term_q <= term_pend;
        end
    end

    always_comb begin
        imm_valid_out  = (state == DONE) && !start_in;
        error_out      = (state == ERR) && !start_in;
        char_ready_out = ((state == SIGN) || (state == ZERO) || (state == HEX) || (state == DEC)) && !start_in;
        imm_out        = imm_valid_out ? result : imm_q;
        term_char_out  = (imm_valid_out || error_out) ? term_pend : term_q;
    end

endmodule

// File: tb/tb_imm_parser.sv
// tb/tb_imm_parser.sv - randomized self-checking bench for imm_parser against a character-level reference model
module tb_imm_parser;

    typedef logic [7:0] q8_t[$];

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        start_in = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid_in = 1'b0;
    logic        char_ready_out;
    logic [31:0] imm_out;
    logic        imm_valid_out;
    logic        error_out;
    logic [7:0]  term_char_out;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ev_valid = 0;
    int          ev_err = 0;
    logic [31:0] last_val = '0;
    logic [31:0] exp_imm = '0;

    imm_parser #(.IMM_WIDTH(32)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .start_in      (start_in),
        .char_in       (char_in),
        .char_valid_in (char_valid_in),
        .char_ready_out(char_ready_out),
        .imm_out       (imm_out),
        .imm_valid_out (imm_valid_out),
        .error_out     (error_out),
        .term_char_out (term_char_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (imm_valid_out) begin
            ev_valid = ev_valid + 1;
            last_val = imm_out;
        end
        if (error_out) ev_err = ev_err + 1;
    end

    function automatic q8_t to_q(input string s);
        q8_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: walk the token character by character; kind 1 = value, 2 = error, 0 = unterminated
    function automatic void model(input q8_t t, output int kind, output logic [31:0] val,
                                  output logic [7:0] term, output int used);
        int              ph;
        bit              neg, seen, dl, dg, hx;
        longint unsigned mag, nxt;
        int              nd, d;
        logic [7:0]      c;
        ph = 0; neg = 0; seen = 0; mag = 0; nd = 0;
        kind = 0; val = '0; term = '0; used = t.size();
        for (int i = 0; i < t.size(); i++) begin
            c  = t[i];
            dl = (c == 8'h20) || (c == 8'h2C) || (c == 8'h28) || (c == 8'h29) ||
                 (c == 8'h0A) || (c == 8'h0D) || (c == 8'h00);
            dg = (c >= 8'h30) && (c <= 8'h39);
            hx = dg || ((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46));
            d  = dg ? int'(c) - 48 : (c >= 8'h61 ? int'(c) - 87 : int'(c) - 55);
            case (ph)
                0: begin
                    if (c == 8'h2D && !seen) begin neg = 1; seen = 1; continue; end
                    else if (c == 8'h30) begin ph = 1; continue; end
                    else if (dg) begin mag = longint'(d); ph = 3; continue; end
                    else kind = 2;
                end
                1: begin
                    if (c == 8'h78 || c == 8'h58) begin ph = 2; continue; end
                    else if (dg) begin mag = longint'(d); ph = 3; continue; end
                    else if (dl) kind = 1;
                    else kind = 2;
                end
                2: begin
                    if (hx) begin
`ifdef IMM_PARSER_RANGE_CHECK_EN
                        if (nd == 8) kind = 2;
`endif
                        if (kind == 0) begin
                            mag = (mag * 16 + longint'(d)) & 64'hFFFF_FFFF;
                            nd++;
                            continue;
                        end
                    end
                    else if (dl && nd > 0) kind = 1;
                    else kind = 2;
                end
                default: begin
                    if (dg) begin
                        nxt = mag * 10 + longint'(d);
`ifdef IMM_PARSER_RANGE_CHECK_EN
                        if (nxt > 64'hFFFF_FFFF) kind = 2;
`endif
                        if (kind == 0) begin
                            mag = nxt & 64'hFFFF_FFFF;
                            continue;
                        end
                    end
                    else if (dl) kind = 1;
                    else kind = 2;
                end
            endcase
`ifdef IMM_PARSER_RANGE_CHECK_EN
            if (kind == 1 && neg && mag > 64'h8000_0000) kind = 2;
`endif
            term = c;
            used = i + 1;
            val  = neg ? 32'(64'h1_0000_0000 - mag) : 32'(mag);
            break;
        end
    endfunction

    task automatic do_start();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    // Returns at the falling edge just after the last character's transfer edge
    task automatic feed(input q8_t t, input int n, input bit gap);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                char_valid_in = 1'b0;
                char_in = 8'h3F;
                @(negedge clk_in);
            end
            char_in = t[i];
            char_valid_in = 1'b1;
            #1;
            w = 0;
            while (!char_ready_out && w < 16) begin
                @(negedge clk_in);
                #1;
                w++;
            end
            if (!char_ready_out) begin
                n_cmp++; n_bad++;
                $display("FAIL ready_timeout char %0d: ready=%0b required 1", i, char_ready_out);
            end
            @(negedge clk_in);
        end
        char_valid_in = 1'b0;
    endtask

    task automatic run_token(input q8_t t, input bit gap);
        int kind, used, v0, e0;
        logic [31:0] val;
        logic [7:0] term;
        model(t, kind, val, term, used);
        do_start();
        v0 = ev_valid; e0 = ev_err;
        feed(t, used, gap);
        #1;
        n_cmp++; if (imm_valid_out !== (kind == 1)) begin n_bad++; $display("FAIL valid_pulse: got %0b required %0b", imm_valid_out, kind == 1); end
        n_cmp++; if (error_out !== (kind == 2)) begin n_bad++; $display("FAIL error_pulse: got %0b required %0b", error_out, kind == 2); end
        if (kind == 1) exp_imm = val;
        n_cmp++; if (imm_out !== exp_imm) begin n_bad++; $display("FAIL imm_out: got %h required %h", imm_out, exp_imm); end
        n_cmp++; if (term_char_out !== term) begin n_bad++; $display("FAIL term_char: got %h required %h", term_char_out, term); end
        n_cmp++; if (char_ready_out !== 1'b0) begin n_bad++; $display("FAIL ready_after_end: got %0b required 0", char_ready_out); end
        @(negedge clk_in);
        #1;
        n_cmp++; if ((imm_valid_out | error_out) !== 1'b0) begin n_bad++; $display("FAIL pulse_width: got %0b required 0", imm_valid_out | error_out); end
        repeat (2) @(negedge clk_in);
        n_cmp++; if ((ev_valid - v0) + (ev_err - e0) !== 1) begin n_bad++; $display("FAIL pulse_count: got %0d required 1", (ev_valid - v0) + (ev_err - e0)); end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (imm_out !== 32'h0) begin n_bad++; $display("FAIL reset_imm: got %h required 0", imm_out); end
        n_cmp++; if (imm_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b required 0", imm_valid_out); end
        n_cmp++; if (error_out !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %0b required 0", error_out); end
        n_cmp++; if (char_ready_out !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %0b required 0", char_ready_out); end
        n_cmp++; if (term_char_out !== 8'h0) begin n_bad++; $display("FAIL reset_term: got %h required 0", term_char_out); end
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        char_valid_in = 1'b1;
        repeat (2) @(negedge clk_in);
        #1;
        n_cmp++; if (char_ready_out !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got %0b required 0", char_ready_out); end
        char_valid_in = 1'b0;
    endtask

    task automatic test_directed();
        string s[10];
        s = '{"0x1F,", "-12 ", "0)", "0x,", "4294967296,", "-0xA(", "--1 ", "12a ", "-2147483648,", "0x123456789\n"};
        for (int i = 0; i < 10; i++) run_token(to_q(s[i]), 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] delims[7];
        string hexs, bads;
        q8_t t;
        int form, n;
        delims = '{8'h20, 8'h2C, 8'h28, 8'h29, 8'h0A, 8'h0D, 8'h00};
        hexs = "0123456789abcdefABCDEF";
        bads = "gxZ-.+";
        for (int k = 0; k < 60; k++) begin
            t.delete();
            form = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) t.push_back(8'h2D);
            if (form == 0 || form == 2) begin
                t.push_back(8'h30); t.push_back(($urandom_range(0, 1) != 0) ? 8'h78 : 8'h58);
                n = $urandom_range(0, 10);
                for (int j = 0; j < n; j++) t.push_back(hexs[$urandom_range(0, 21)]);
            end else begin
                t.push_back(8'(8'h30 + $urandom_range(0, 9)));
                n = $urandom_range(0, 10);
                for (int j = 0; j < n; j++) t.push_back(8'(8'h30 + $urandom_range(0, 9)));
            end
            if (form >= 2) t.push_back(bads[$urandom_range(0, 5)]);
            t.push_back(delims[$urandom_range(0, 6)]);
            run_token(t, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_abort();
        int v0, e0;
        v0 = ev_valid; e0 = ev_err;
        do_start();
        feed(to_q("12"), 2, 1'b0);
        start_in = 1'b1;
        #1;
        n_cmp++; if (char_ready_out !== 1'b0) begin n_bad++; $display("FAIL start_ready: got %0b required 0", char_ready_out); end
        @(negedge clk_in);
        start_in = 1'b0;
        feed(to_q("7\n"), 2, 1'b0);
        repeat (3) @(negedge clk_in);
        n_cmp++; if (ev_valid - v0 !== 1) begin n_bad++; $display("FAIL abort_count: got %0d required 1", ev_valid - v0); end
        n_cmp++; if (last_val !== 32'd7) begin n_bad++; $display("FAIL abort_value: got %h required 7", last_val); end
        exp_imm = 32'd7;
        // start_in landing on the DONE cycle must swallow the pulse and keep imm_out
        v0 = ev_valid;
        do_start();
        feed(to_q("5,"), 2, 1'b0);
        start_in = 1'b1;
        #1;
        n_cmp++; if (imm_valid_out !== 1'b0) begin n_bad++; $display("FAIL suppress_valid: got %0b required 0", imm_valid_out); end
        n_cmp++; if (imm_out !== exp_imm) begin n_bad++; $display("FAIL suppress_imm: got %h required %h", imm_out, exp_imm); end
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (2) @(negedge clk_in);
        n_cmp++; if (ev_valid - v0 !== 0 || ev_err - e0 !== 0) begin n_bad++; $display("FAIL suppress_count: got %0d required 0", ev_valid - v0 + ev_err - e0); end
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        v0 = ev_valid; e0 = ev_err;
        do_start();
        feed(to_q("0xF"), 3, 1'b1);
        char_in = 8'h46;
        char_valid_in = 1'b1;
        #2;
        rst_n_in = 1'b0;
        #1;
        n_cmp++; if (imm_out !== 32'h0) begin n_bad++; $display("FAIL midrst_imm: got %h required 0", imm_out); end
        n_cmp++; if ({imm_valid_out, error_out, char_ready_out} !== 3'b000) begin n_bad++; $display("FAIL midrst_flags: got %b required 000", {imm_valid_out, error_out, char_ready_out}); end
        n_cmp++; if (term_char_out !== 8'h0) begin n_bad++; $display("FAIL midrst_term: got %h required 0", term_char_out); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        exp_imm = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            #1;
            n_cmp++; if (char_ready_out !== 1'b0) begin n_bad++; $display("FAIL postrst_ready cycle %0d: got %0b required 0", i, char_ready_out); end
        end
        char_valid_in = 1'b0;
        n_cmp++; if (ev_valid - v0 + ev_err - e0 !== 0) begin n_bad++; $display("FAIL midrst_pulse: got %0d required 0", ev_valid - v0 + ev_err - e0); end
        run_token(to_q("0xFF "), 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
